// File: rtl/sobel_engine.sv
// rtl/sobel_engine.sv - frame-level Sobel controller driving the row cache's sequential read/write ports
module sobel_engine #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        en_o,
  output logic        we_o,
  output logic [31:0] di_o,
  output logic        finish_o,
  input  logic        row_cached_i,
  input  logic [31:0] doa_i,
  input  logic [31:0] dob_i,
  input  logic [31:0] doc_i
);
  localparam int RW    = WIDTH / 4;
  localparam int TOTAL = HEIGHT * RW;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(RW + 1);
  localparam int YW    = $clog2(HEIGHT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ZTOP, S_FILL, S_PROC, S_DRAIN, S_ZBOT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic            phase_q, phase_d;
  logic            busy_q, busy_d, done_q, done_d, fin_q, fin_d;
  logic            en_q, en_d, we_q, we_d, tag_q, tag_d;
  logic [31:0]     di_q, di_d;
  logic            pop;

  logic [RD_LAT-1:0] vsr_q;
  logic              valid;
  logic [31:0]       win_q [3][3];
  logic [XW-1:0]     in_col_q, ctr_col_q;
  logic [YW-1:0]     in_row_q;
  logic              evt_q, rmask_q, flush_q;
  logic [7:0]        nb [3][6];
  logic [31:0]       res;

  logic [31:0]     fifo_q [4];
  logic [1:0]      fwr_q, frd_q;
  logic [2:0]      fcnt_q;

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign en_o     = en_q;
  assign we_o     = we_q;
  assign di_o     = di_q;
  assign finish_o = fin_q;
  assign valid    = vsr_q[RD_LAT-1];

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    phase_d  = phase_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fin_d    = 1'b0;
    en_d     = 1'b0;
    we_d     = 1'b0;
    tag_d    = 1'b0;
    di_d     = '0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        busy_d   = 1'b1;
        en_d     = 1'b1;
        we_d     = 1'b1;
        wr_cnt_d = CW'(1);
        rd_cnt_d = '0;
        phase_d  = 1'b0;
        state_d  = (RW == 1) ? S_FILL : S_ZTOP;
      end
      S_ZTOP: begin
        en_d     = 1'b1;
        we_d     = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_d == CW'(RW)) state_d = S_FILL;
      end
      S_FILL: begin
        en_d     = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_d == CW'(2 * RW)) state_d = S_PROC;
      end
      S_PROC: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          en_d     = 1'b1;
          tag_d    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_d == CW'(TOTAL)) state_d = S_DRAIN;
        end else if (fcnt_q != 3'd0) begin
          en_d     = 1'b1;
          we_d     = 1'b1;
          di_d     = fifo_q[frd_q];
          pop      = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      S_DRAIN: if (fcnt_q != 3'd0) begin
        en_d     = 1'b1;
        we_d     = 1'b1;
        di_d     = fifo_q[frd_q];
        pop      = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_d == CW'((HEIGHT - 1) * RW)) state_d = S_ZBOT;
      end
      S_ZBOT: begin
        en_d     = 1'b1;
        we_d     = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_d == CW'(TOTAL)) state_d = S_DONE;
      end
      S_DONE: begin
        fin_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fin_q    <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      tag_q    <= 1'b0;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fin_q    <= fin_d;
      en_q     <= en_d;
      we_q     <= we_d;
      tag_q    <= tag_d;
      di_q     <= di_d;
    end
  end

  function automatic logic [7:0] sobel_px(input logic [7:0] tl, tc, tr, ml, mr, bl, bc, br);
    logic signed [10:0] gx, gy;
    logic [10:0]        ax, ay;
    logic [11:0]        s;
    gx = ($signed({3'b000, tr}) + $signed({2'b00, mr, 1'b0}) + $signed({3'b000, br}))
       - ($signed({3'b000, tl}) + $signed({2'b00, ml, 1'b0}) + $signed({3'b000, bl}));
    gy = ($signed({3'b000, bl}) + $signed({2'b00, bc, 1'b0}) + $signed({3'b000, br}))
       - ($signed({3'b000, tl}) + $signed({2'b00, tc, 1'b0}) + $signed({3'b000, tr}));
    ax = gx[10] ? 11'(-gx) : 11'(gx);
    ay = gy[10] ? 11'(-gy) : 11'(gy);
    s  = {1'b0, ax} + {1'b0, ay};
    return (s > 12'd255) ? 8'hff : s[7:0];
  endfunction

  // Centre column is win_q[*][1]; only the facing edge pixel of each neighbour column matters.
  always_comb begin
    res = '0;
    for (int r = 0; r < 3; r++) begin
      nb[r][0] = win_q[r][0][7:0];
      for (int p = 0; p < 4; p++) nb[r][p+1] = win_q[r][1][31-8*p -: 8];
      nb[r][5] = rmask_q ? 8'h00 : win_q[r][2][31:24];
    end
    for (int p = 0; p < 4; p++)
      res[31-8*p -: 8] = sobel_px(nb[0][p], nb[0][p+1], nb[0][p+2], nb[1][p], nb[1][p+2],
                                  nb[2][p], nb[2][p+1], nb[2][p+2]);
    if (ctr_col_q == '0)          res[31:24] = 8'h00;
    if (ctr_col_q == XW'(RW - 1)) res[7:0]   = 8'h00;
  end

  // A column-0 arrival masks the right neighbour, which turns its event into the previous row's flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr_q     <= '0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      ctr_col_q <= '0;
      evt_q     <= 1'b0;
      rmask_q   <= 1'b0;
      flush_q   <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else begin
      vsr_q   <= RD_LAT'({vsr_q, tag_q});
      evt_q   <= 1'b0;
      flush_q <= 1'b0;
      if (state_q == S_IDLE) begin
        in_col_q <= '0;
        in_row_q <= '0;
      end else if (valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= doa_i;
        win_q[1][2] <= dob_i;
        win_q[2][2] <= doc_i;
        evt_q     <= !(in_col_q == '0 && in_row_q == '0);
        rmask_q   <= (in_col_q == '0);
        ctr_col_q <= (in_col_q == '0) ? XW'(RW - 1) : in_col_q - 1'b1;
        if (in_col_q == XW'(RW - 1)) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + 1'b1;
          flush_q  <= (in_row_q == YW'(HEIGHT - 3));
        end else begin
          in_col_q <= in_col_q + 1'b1;
        end
      end else if (flush_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= '0;
        end
        evt_q     <= 1'b1;
        rmask_q   <= 1'b1;
        ctr_col_q <= XW'(RW - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwr_q  <= '0;
      frd_q  <= '0;
      fcnt_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      if (evt_q) begin
        fifo_q[fwr_q] <= res;
        fwr_q         <= fwr_q + 1'b1;
      end
      if (pop) frd_q <= frd_q + 1'b1;
      fcnt_q <= fcnt_q + 3'(evt_q) - 3'(pop);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(evt_q && !pop && fcnt_q == 3'd4));
      assert (!(state_q == S_PROC && !row_cached_i));
    end
  end
endmodule

// File: tb/tb_sobel_engine.sv
// tb/tb_sobel_engine.sv - bench with a row-cache responder and a frame-level Sobel reference
module tb_sobel_engine;
  localparam int WIDTH = 16, HEIGHT = 8, RD_LAT = 2;
  localparam int RW = WIDTH / 4, NW = HEIGHT * RW;

  logic        clk = 1'b0;
  logic        rst, start_i, row_cached_i;
  logic        busy_o, done_o, en_o, we_o, finish_o;
  logic [31:0] di_o, doa_i, dob_i, doc_i;

  always #5 clk = ~clk;

  sobel_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .en_o(en_o), .we_o(we_o), .di_o(di_o), .finish_o(finish_o),
    .row_cached_i(row_cached_i), .doa_i(doa_i), .dob_i(dob_i), .doc_i(doc_i)
  );

  logic [7:0]  frame [HEIGHT][WIDTH];
  logic [31:0] got [NW];
  int          pipe [RD_LAT+1];
  int          rd_n, wr_n, last_rd, last_wr, done_n = 0, fin_bad = 0;
  int          total = 0, bad = 0;

  function automatic logic [31:0] pack(int r, int k);
    logic [31:0] w = '0;
    if (r >= 0) for (int p = 0; p < 4; p++) w[31-8*p -: 8] = frame[r][4*k+p];
    return w;
  endfunction

  function automatic int px(int y, int x);
    return int'(frame[y][x]);
  endfunction

  function automatic int ref_pix(int y, int x);
    int gx, gy, s;
    if (y == 0 || y == HEIGHT-1 || x == 0 || x == WIDTH-1) return 0;
    gx = px(y-1,x+1) + 2*px(y,x+1) + px(y+1,x+1) - (px(y-1,x-1) + 2*px(y,x-1) + px(y+1,x-1));
    gy = px(y+1,x-1) + 2*px(y+1,x) + px(y+1,x+1) - (px(y-1,x-1) + 2*px(y-1,x) + px(y-1,x+1));
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  // Row cache: sequential addresses, RD_LAT read latency, garbage outside valid slots.
  always @(negedge clk) begin
    if (rst) begin
      rd_n = 0; wr_n = 0;
      for (int i = 0; i <= RD_LAT; i++) pipe[i] = -1;
      doa_i = '0; dob_i = '0; doc_i = '0;
    end else begin
      for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = -1;
      if (en_o && !we_o) begin pipe[0] = rd_n; rd_n++; end
      if (en_o && we_o) begin if (wr_n < NW) got[wr_n] = di_o; wr_n++; end
      if (pipe[RD_LAT] >= 0) begin
        doa_i = pack(pipe[RD_LAT]/RW - 2, pipe[RD_LAT]%RW);
        dob_i = pack(pipe[RD_LAT]/RW - 1, pipe[RD_LAT]%RW);
        doc_i = pack(pipe[RD_LAT]/RW,     pipe[RD_LAT]%RW);
      end else begin
        doa_i = $urandom; dob_i = $urandom; doc_i = $urandom;
      end
      if (done_o) done_n++;
      if (finish_o != done_o) fin_bad++;
      if (finish_o) begin last_rd = rd_n; last_wr = wr_n; rd_n = 0; wr_n = 0; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        case (mode)
          0: frame[y][x] = 8'h00;
          1: frame[y][x] = 8'h80;
          2: frame[y][x] = (x >= 8) ? 8'hff : 8'h00;
          3: frame[y][x] = (y == 3 && x == 5) ? 8'h40 : 8'h00;
          default: frame[y][x] = 8'($urandom);
        endcase
  endtask

  task automatic run_frame(input string name, input bit poke_start);
    int d0, f0, cyc;
    logic [31:0] e;
    d0 = done_n; f0 = fin_bad;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    cyc = 0;
    while (done_n == d0 && cyc < 2000) begin
      start_i = poke_start && (cyc == 30);
      @(posedge clk); #1; cyc++;
    end
    start_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({name, ".done_count"}, 32'(done_n - d0), 32'd1);
    check({name, ".finish_with_done"}, 32'(fin_bad - f0), 32'd0);
    check({name, ".rd_count"}, 32'(last_rd), 32'(NW));
    check({name, ".wr_count"}, 32'(last_wr), 32'(NW));
    check({name, ".busy_after"}, 32'(busy_o), 32'd0);
    for (int y = 0; y < HEIGHT; y++)
      for (int k = 0; k < RW; k++) begin
        e = '0;
        for (int p = 0; p < 4; p++) e[31-8*p -: 8] = 8'(ref_pix(y, 4*k+p));
        check($sformatf("%s.word_r%0d_c%0d", name, y, k), got[y*RW+k], e);
      end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; row_cached_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.done", 32'(done_o), 32'd0);
    check("reset.en", 32'(en_o), 32'd0);
    check("reset.we", 32'(we_o), 32'd0);
    check("reset.di", di_o, 32'd0);
    check("reset.finish", 32'(finish_o), 32'd0);
    rst = 1'b0;

    fill(0); run_frame("zero", 1'b0);
    fill(1); run_frame("const80", 1'b0);
    fill(2); run_frame("vedge", 1'b0);
    check("vedge.px7_row3", 32'(got[3*RW+1][7:0]), 32'hff);
    check("vedge.px8_row3", 32'(got[3*RW+2][31:24]), 32'hff);
    fill(3); run_frame("dot", 1'b0);
    check("dot.r2c4", 32'(got[2*RW+1][31:24]), 32'h80);
    check("dot.r2c5", 32'(got[2*RW+1][23:16]), 32'h80);
    fill(4); run_frame("rand_restart", 1'b1);

    fill(4);
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (35) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort.en", 32'(en_o), 32'd0);
    check("abort.busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    fill(4); run_frame("after_abort", 1'b0);
    fill(4); run_frame("rand2", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
